disp_scan_ctrl: RTL and testbench



---
 rtl/disp_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Scan sequencer for a 4-digit multiplexed display. It walks the digit-value
// mux select through digits 0..3. Each digit slot has two phases:
//   - a dead-time with all anodes off, to stop ghosting while the mux settles;
//   - an on-time that drives that digit's active-low anode.
// It also provides per-digit masking (latched once per frame), a
// half-brightness dim mode and a one-cycle frame tick.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   en_i          scan enable; dropping it abandons the frame and returns to idle
//   digit_en_i    per-digit enable request, sampled only at frame boundaries
//   dim_i         1 = anode asserted only for the first half of each drive phase
//   sel_o         2-bit select to the digit-value mux, stable for a whole slot
//   anode_n_o     registered active-low anode drive, at most one bit low
//   frame_tick_o  one-cycle pulse after the edge that ends digit 3's slot
module disp_scan_ctrl #(
  parameter int DEAD_CYCLES = 4,
  parameter int ON_CYCLES   = 12496
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic [3:0] digit_en_i,
  input  logic       dim_i,
  output logic [1:0] sel_o,
  output logic [3:0] anode_n_o,
  output logic       frame_tick_o
);

  localparam int MAXC  = (DEAD_CYCLES > ON_CYCLES) ? DEAD_CYCLES : ON_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_HALF   = CNT_W'(ON_CYCLES / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       mask_q, mask_d;
  logic             tick_q, tick_d;
  logic [3:0]       anode_n_q, anode_n_d;

  // State register. The anode drive is registered alongside the state, so the
  // output is glitch-free and has no combinational path from any input.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= 2'd0;
      mask_q    <= 4'hF;
      tick_q    <= 1'b0;
      anode_n_q <= 4'hF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      tick_q    <= tick_d;
      anode_n_q <= anode_n_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = 2'd0;
          mask_d  = digit_en_i;
        end
      end
      BLANK: begin
        if (!en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end else if (cnt_q == DEAD_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRIVE: begin
        if (!en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = 2'd0;
        end else if (cnt_q == ON_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = sel_q + 2'd1;
          // End of digit 3's slot is the frame boundary: the mask is reloaded
          // only here, so mid-frame enable changes wait for the next frame.
          if (sel_q == 2'd3) begin
            tick_d = 1'b1;
            mask_d = digit_en_i;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sel_d   = 2'd0;
      end
    endcase
  end

  // Output decode. It is computed from the next-state values so that the
  // registered anode lines up with the state, count and select it belongs to.
  // DIM is taken live, so a change affects the rest of the current slot.
  always_comb begin
    anode_n_d = 4'hF;
    if ((state_d == DRIVE) && mask_d[sel_d] && (!dim_i || (cnt_d < ON_HALF))) begin
      anode_n_d = ~(4'b0001 << sel_d);
    end
  end

  assign sel_o        = sel_q;
  assign anode_n_o    = anode_n_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] digit_en = 4'hF;
  logic       dim = 1'b0;
  logic [1:0] sel;
  logic [3:0] anode_n;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  // Scan position: n counts edges since EN was applied (n=1 is the first edge
  // that samples EN=1); mask_m is the mask expected to be active.
  int         n = 0;
  logic [3:0] mask_m = 4'hF;
  int         tick_count = 0;

  disp_scan_ctrl #(
    .DEAD_CYCLES(2),
    .ON_CYCLES  (4)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .digit_en_i  (digit_en),
    .dim_i       (dim),
    .sel_o       (sel),
    .anode_n_o   (anode_n),
    .frame_tick_o(frame_tick)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slot = 6 cycles (2 blank + 4 drive), frame = 24 cycles.
  task automatic run_check(input int k);
    int         phase;
    int         slot;
    logic [3:0] exp_an;
    logic       exp_tick;
    for (int i = 0; i < k; i++) begin
      step();
      n++;
      phase = (n - 1) % 6;
      slot  = ((n - 1) / 6) % 4;
      if ((n - 1) % 24 == 0) mask_m = digit_en;
      exp_tick = (n > 1) && ((n - 1) % 24 == 0);
      exp_an = 4'hF;
      if (phase >= 2 && mask_m[slot] && (!dim || (phase - 2) < 2))
        exp_an = ~(4'b0001 << slot);
      if (frame_tick === 1'b1) tick_count++;
      chk("sel", {6'd0, sel}, 8'(slot));
      chk("anode_n", {4'd0, anode_n}, {4'd0, exp_an});
      chk("frame_tick", {7'd0, frame_tick}, {7'd0, exp_tick});
    end
  endtask

  // Hand-written first 12 cycles after enable with all digits on.
  task automatic start_table();
    logic [3:0] an_tab [12];
    logic [1:0] sel_tab [12];
    an_tab  = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
                4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD};
    sel_tab = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
    for (int i = 0; i < 12; i++) begin
      step();
      chk("start_anode", {4'd0, anode_n}, {4'd0, an_tab[i]});
      chk("start_sel", {6'd0, sel}, {6'd0, sel_tab[i]});
    end
    n = 12;
    mask_m = 4'hF;
  endtask

  initial begin
    // Async reset with no clock edge involved.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_anode", {4'd0, anode_n}, 8'h0F);
    chk("rst_sel", {6'd0, sel}, 8'h00);
    chk("rst_tick", {7'd0, frame_tick}, 8'h00);
    step();
    step();
    rst_n = 1'b1;

    // Idle with EN low.
    step();
    chk("idle_anode", {4'd0, anode_n}, 8'h0F);
    chk("idle_sel", {6'd0, sel}, 8'h00);
    step();
    chk("idle_anode2", {4'd0, anode_n}, 8'h0F);
    chk("idle_tick", {7'd0, frame_tick}, 8'h00);

    // Scenario 1: enable.
    en = 1'b1;
    start_table();

    // Scenario 2: three frame ticks over free run (n 13..84).
    tick_count = 0;
    run_check(72);
    chk("tick_count", 8'(tick_count), 8'd3);

    // Scenario 3: n=84 is inside digit 1's slot; new mask applies at n=97.
    digit_en = 4'b0101;
    run_check(48);

    // Scenario 4: dim for a while, then clear it at the edge into CNT=2.
    dim = 1'b1;
    run_check(40);       // n=172: slot 0, CNT=1
    dim = 1'b0;
    run_check(6);        // n=178

    // Scenario 5: drop EN at slot 2, CNT=1 (n=184).
    run_check(6);
    chk("pre_dis_sel", {6'd0, sel}, 8'd2);
    en = 1'b0;
    step();
    chk("dis_anode", {4'd0, anode_n}, 8'h0F);
    chk("dis_sel", {6'd0, sel}, 8'h00);
    chk("dis_tick", {7'd0, frame_tick}, 8'h00);
    step();
    chk("dis_idle_anode", {4'd0, anode_n}, 8'h0F);
    en = 1'b1;
    n = 0;
    run_check(3);
    chk("reen_anode", {4'd0, anode_n}, 8'h0E);
    run_check(3);

    // Scenario 6: async reset mid-drive of digit 1 (n=10, CNT=1).
    digit_en = 4'hF;
    run_check(4);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_anode", {4'd0, anode_n}, 8'h0F);
    chk("arst_sel", {6'd0, sel}, 8'h00);
    chk("arst_tick", {7'd0, frame_tick}, 8'h00);
    step();
    chk("arst_hold_anode", {4'd0, anode_n}, 8'h0F);
    rst_n = 1'b1;
    start_table();
    tick_count = 0;
    run_check(24);
    chk("tick_count2", 8'(tick_count), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
